// File: rtl/host_cmd_decoder_if.sv
// Host parallel byte bus: transfer strobe, command/data byte and the returned ack.
interface host_cmd_decoder_if;
    logic       i_sync;
    logic       i_cmd;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic       o_sync;

    modport master (output i_sync, i_cmd, i_data, input  o_data, o_sync);
    modport slave  (input  i_sync, i_cmd, i_data, output o_data, o_sync);
endinterface

// File: rtl/host_cmd_decoder.sv
// Host command front end: decodes host bytes into transmitter write controls and acks.
// Optional macro HOST_ERRCNT_EN adds a rejected-transfer counter readable by opcode 0x14.
module host_cmd_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WRITE_MAX   = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    host_cmd_decoder_if.slave   host,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_data_we,
    output logic                o_push_write_index,
    output logic                o_pop_write_index,
    output logic                o_push_frame,
    input  logic [15:0]         i_tx_data_size,
    input  logic [7:0]          i_tx_frames_count,
    input  logic [7:0]          i_tx_status
);
    typedef enum logic {S_IDLE, S_WRITE} state_t;

    localparam logic [7:0]  MASK_END  = 8'(SYNC_STAGES + 1);
    localparam logic [15:0] BURST_MAX = 16'(WRITE_MAX);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic [7:0]             r_mask_cnt;
    logic                   w_edge;

    state_t      r_state;
    logic [15:0] r_burst_cnt;
    logic        r_ack_pend;
    logic [7:0]  r_ack_byte;
    logic [7:0]  w_ack_out;

    logic [7:0]  w_ack;
    logic        w_reject;
    logic        w_we;
    logic        w_push_idx;
    logic        w_pop_idx;
    logic        w_push_frame;
    logic        w_enter_write;

    // Edge detection stays masked until the previous-value flop has caught up after reset.
    assign w_edge = (r_mask_cnt == MASK_END) && (r_sync[SYNC_STAGES-1] != r_sync_prev);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_mask_cnt  <= '0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], host.i_sync};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
            if (r_mask_cnt != MASK_END)
                r_mask_cnt <= r_mask_cnt + 8'd1;
        end
    end

`ifdef HOST_ERRCNT_EN
    logic [7:0] r_errcnt;
    logic       r_ack_errcnt;
    logic       w_ack_errcnt;
    logic       w_err_inc;

    assign w_err_inc = w_edge && w_reject;
    assign w_ack_out = r_ack_errcnt ? r_errcnt : r_ack_byte;

    // Readback clears the counter, but an error decoded in the same cycle survives as 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_errcnt     <= '0;
            r_ack_errcnt <= 1'b0;
        end else begin
            if (w_edge)
                r_ack_errcnt <= w_ack_errcnt;
            if (r_ack_pend && r_ack_errcnt)
                r_errcnt <= w_err_inc ? 8'd1 : 8'd0;
            else if (w_err_inc && r_errcnt != '1)
                r_errcnt <= r_errcnt + 8'd1;
        end
    end
`else
    assign w_ack_out = r_ack_byte;
`endif

    always_comb begin
        w_ack         = '0;
        w_reject      = 1'b0;
        w_we          = 1'b0;
        w_push_idx    = 1'b0;
        w_pop_idx     = 1'b0;
        w_push_frame  = 1'b0;
        w_enter_write = 1'b0;
`ifdef HOST_ERRCNT_EN
        w_ack_errcnt  = 1'b0;
`endif
        if (host.i_cmd) begin
            case (host.i_data)
                8'h01: begin w_enter_write = 1'b1; w_ack = 8'h01; end
                8'h02: begin w_push_idx    = 1'b1; w_ack = 8'h02; end
                8'h03: begin w_pop_idx     = 1'b1; w_ack = 8'h03; end
                8'h04: begin w_push_frame  = 1'b1; w_ack = 8'h04; end
                8'h10: w_ack = i_tx_data_size[7:0];
                8'h11: w_ack = i_tx_data_size[15:8];
                8'h12: w_ack = i_tx_frames_count;
                8'h13: w_ack = i_tx_status;
`ifdef HOST_ERRCNT_EN
                8'h14: w_ack_errcnt = 1'b1;
`endif
                default: begin w_ack = 8'hEE; w_reject = 1'b1; end
            endcase
        end else if (r_state == S_WRITE && r_burst_cnt < BURST_MAX) begin
            w_we  = 1'b1;
            w_ack = host.i_data;
        end else begin
            w_ack    = 8'hEE;
            w_reject = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state            <= S_IDLE;
            r_burst_cnt        <= '0;
            r_ack_pend         <= 1'b0;
            r_ack_byte         <= '0;
            o_tx_data          <= '0;
            o_tx_data_we       <= 1'b0;
            o_push_write_index <= 1'b0;
            o_pop_write_index  <= 1'b0;
            o_push_frame       <= 1'b0;
            host.o_data        <= '0;
            host.o_sync        <= 1'b0;
        end else begin
            o_tx_data_we       <= w_edge && w_we;
            o_push_write_index <= w_edge && w_push_idx;
            o_pop_write_index  <= w_edge && w_pop_idx;
            o_push_frame       <= w_edge && w_push_frame;
            r_ack_pend         <= w_edge;
            if (w_edge) begin
                r_ack_byte <= w_ack;
                if (host.i_cmd) begin
                    r_state <= w_enter_write ? S_WRITE : S_IDLE;
                    if (w_enter_write)
                        r_burst_cnt <= '0;
                end else if (w_we) begin
                    o_tx_data   <= host.i_data;
                    r_burst_cnt <= r_burst_cnt + 16'd1;
                end
            end
            if (r_ack_pend) begin
                host.o_data <= w_ack_out;
                host.o_sync <= ~host.o_sync;
            end
        end
    end
endmodule

// File: tb/tb_host_cmd_decoder.sv
// Directed bench for host_cmd_decoder with a transaction-level model and per-cycle compare.
module tb_host_cmd_decoder;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned WRITE_MAX   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_we, push_idx, pop_idx, push_frame;
    logic [15:0] tx_size = 16'h0000;
    logic [7:0]  tx_frames = 8'h00;
    logic [7:0]  tx_status = 8'h00;

    host_cmd_decoder_if u_if ();

    host_cmd_decoder #(.SYNC_STAGES(SYNC_STAGES), .WRITE_MAX(WRITE_MAX)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .host               (u_if),
        .o_tx_data          (tx_data),
        .o_tx_data_we       (tx_we),
        .o_push_write_index (push_idx),
        .o_pop_write_index  (pop_idx),
        .o_push_frame       (push_frame),
        .i_tx_data_size     (tx_size),
        .i_tx_frames_count  (tx_frames),
        .i_tx_status        (tx_status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] vec;   // {we, push_idx, pop_idx, push_frame}
        logic [7:0] data;
    } strobe_t;

    strobe_t    exp_strobe[$];
    logic [7:0] exp_ack[$];

    // Model state: write mode, burst count, rejected-transfer count
    bit m_write;
    int m_cnt;
    int m_err;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_write = 1'b0;
        m_cnt   = 0;
        m_err   = 0;
        exp_strobe.delete();
        exp_ack.delete();
    endfunction

    function automatic void model_reject();
        exp_ack.push_back(8'hEE);
        if (m_err < 255) m_err++;
    endfunction

    function automatic void model(input logic cmd, input logic [7:0] d);
        strobe_t s;
        s.data = 8'h00;
        if (cmd) begin
            m_write = (d == 8'h01);
            case (d)
                8'h01: begin m_cnt = 0; exp_ack.push_back(8'h01); end
                8'h02: begin s.vec = 4'b0100; exp_strobe.push_back(s); exp_ack.push_back(8'h02); end
                8'h03: begin s.vec = 4'b0010; exp_strobe.push_back(s); exp_ack.push_back(8'h03); end
                8'h04: begin s.vec = 4'b0001; exp_strobe.push_back(s); exp_ack.push_back(8'h04); end
                8'h10: exp_ack.push_back(tx_size[7:0]);
                8'h11: exp_ack.push_back(tx_size[15:8]);
                8'h12: exp_ack.push_back(tx_frames);
                8'h13: exp_ack.push_back(tx_status);
`ifdef HOST_ERRCNT_EN
                8'h14: begin exp_ack.push_back(8'(m_err)); m_err = 0; end
`endif
                default: model_reject();
            endcase
        end else if (m_write && m_cnt < WRITE_MAX) begin
            s.vec  = 4'b1000;
            s.data = d;
            exp_strobe.push_back(s);
            exp_ack.push_back(d);
            m_cnt++;
        end else begin
            model_reject();
        end
    endfunction

    // Per-cycle compare of strobes and acks against the model queues
    logic last_sync = 1'b0;
    always @(negedge clk) begin
        logic [3:0] v;
        strobe_t    s;
        logic [7:0] a;
        if (!rst_n) begin
            last_sync = 1'b0;
        end else begin
            v = {tx_we, push_idx, pop_idx, push_frame};
            if (v != 4'b0000) begin
                if (exp_strobe.size() == 0) begin
                    check("unexpected_strobe", {12'h0, v}, 16'h0);
                end else begin
                    s = exp_strobe.pop_front();
                    check("strobe_kind", {12'h0, v}, {12'h0, s.vec});
                    if (s.vec[3]) check("tx_data", {8'h0, tx_data}, {8'h0, s.data});
                end
            end
            if (u_if.o_sync !== last_sync) begin
                last_sync = u_if.o_sync;
                if (exp_ack.size() == 0) begin
                    check("unexpected_ack", {8'h0, u_if.o_data}, 16'hFFFF);
                end else begin
                    a = exp_ack.pop_front();
                    check("ack_data", {8'h0, u_if.o_data}, {8'h0, a});
                end
            end
        end
    end

    // One host transfer; lit < 0 skips the hand-computed literal check
    task automatic send(input logic cmd, input logic [7:0] d, input int lit);
        logic prev;
        int   cyc;
        model(cmd, d);
        @(posedge clk); #1;
        u_if.i_cmd  = cmd;
        u_if.i_data = d;
        u_if.i_sync = ~u_if.i_sync;
        prev = u_if.o_sync;
        cyc  = 0;
        while (u_if.o_sync === prev && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (u_if.o_sync === prev) begin
            check("ack_timeout", 16'(cyc), 16'hFFFF);
        end else begin
            checks++;
            if (cyc < SYNC_STAGES + 2 || cyc > SYNC_STAGES + 3) begin
                failures++;
                $display("FAIL ack_latency got=%0d exp=%0d..%0d", cyc, SYNC_STAGES + 2, SYNC_STAGES + 3);
            end
            if (lit >= 0) check("ack_literal", {8'h0, u_if.o_data}, 16'(lit));
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        u_if.i_sync = 1'b1;
        u_if.i_cmd  = 1'b0;
        u_if.i_data = 8'h00;
        rst_n = 1'b0;
        idle_cycles(3);
        check("rst_o_data", {8'h0, u_if.o_data}, 16'h0000);
        check("rst_o_sync", {15'h0, u_if.o_sync}, 16'h0000);
        check("rst_tx_data", {8'h0, tx_data}, 16'h0000);
        check("rst_strobes", {12'h0, tx_we, push_idx, pop_idx, push_frame}, 16'h0000);
        rst_n = 1'b1;
        idle_cycles(10);
        check("held_sync_no_ack", {15'h0, u_if.o_sync}, 16'h0000);

        // Write burst, overflow past WRITE_MAX, then frame push
        send(1'b1, 8'h01, 8'h01);
        send(1'b0, 8'hA5, 8'hA5);
        send(1'b0, 8'h3C, 8'h3C);
        check("o_sync_after_3", {15'h0, u_if.o_sync}, 16'h0001);
        check("tx_data_hold", {8'h0, tx_data}, 16'h003C);
        send(1'b0, 8'h77, 8'hEE);
        send(1'b1, 8'h04, 8'h04);

        // Status readback
        tx_size   = 16'h1234;
        tx_frames = 8'h56;
        tx_status = 8'h81;
        send(1'b1, 8'h10, 8'h34);
        send(1'b1, 8'h11, 8'h12);
        send(1'b1, 8'h12, 8'h56);
        send(1'b1, 8'h13, 8'h81);
        send(1'b1, 8'h03, 8'h03);

        // Rejects and the error counter
        model_reset();
        rst_n = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(10);
        send(1'b0, 8'h55, 8'hEE);
        send(1'b1, 8'h7F, 8'hEE);
`ifdef HOST_ERRCNT_EN
        send(1'b1, 8'h14, 8'h02);
        send(1'b1, 8'h14, 8'h00);
`else
        send(1'b1, 8'h14, 8'hEE);
`endif

        // A command inside a burst leaves write mode before executing
        send(1'b1, 8'h01, 8'h01);
        send(1'b0, 8'h11, 8'h11);
        send(1'b1, 8'h02, 8'h02);
        send(1'b0, 8'h22, 8'hEE);

        // Reset during E of a data byte aborts it
        send(1'b1, 8'h01, 8'h01);
        @(posedge clk); #1;
        u_if.i_cmd  = 1'b0;
        u_if.i_data = 8'h5A;
        u_if.i_sync = ~u_if.i_sync;
        repeat (SYNC_STAGES) @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        idle_cycles(3);
        check("abort_o_sync", {15'h0, u_if.o_sync}, 16'h0000);
        check("abort_we", {15'h0, tx_we}, 16'h0000);
        check("abort_tx_data", {8'h0, tx_data}, 16'h0000);
        rst_n = 1'b1;
        idle_cycles(10);
        check("abort_no_late_ack", {15'h0, u_if.o_sync}, 16'h0000);
        send(1'b0, 8'h99, 8'hEE);

        idle_cycles(5);
        check("ack_queue_drained", 16'(exp_ack.size()), 16'h0000);
        check("strobe_queue_drained", 16'(exp_strobe.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/host_cmd_decoder.md
# host_cmd_decoder

Host-side command front end for the CPLD frame transmitter. It takes the host's parallel byte bus (i_sync/i_cmd/i_data) and decodes command and data bytes. It drives the transmitter's write-side controls (data write, write-index push/pop, frame push). It also returns one acknowledge byte per transfer on o_data/o_sync, carrying transmitter status on request.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for i_sync (≥2).
- WRITE_MAX, 1024: max data bytes accepted per WRITE burst (1..65535).

Ports:
- i_clk  in  1  system clock (transmitter's i_clk domain).
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_sync  in  1  host transfer strobe, asynchronous; every toggle (either edge) is one transfer.
- i_cmd  in  1  1 = command byte, 0 = data byte; stable from before the i_sync toggle until the ack.
- i_data  in  8  opcode or data byte.
- o_data  out  8  acknowledge/readback byte.
- o_sync  out  1  ack toggle; flips once per completed transfer.
- o_tx_data  out  8  byte to transmitter.
- o_tx_data_we  out  1  one-cycle write strobe.
- o_push_write_index, o_pop_write_index, o_push_frame  out  1 each  one-cycle strobes.
- i_tx_data_size  in  16  transmitter o_data_size.
- i_tx_frames_count  in  8.
- i_tx_status  in  8.

## Operation
- i_sync passes through a SYNC_STAGES flop chain, followed by a previous-value flop. A transfer is detected in the cycle E when the sync output differs from the previous value.
- At E, the block captures i_cmd, i_data, i_tx_data_size, i_tx_frames_count and i_tx_status.
- FSM states: S_IDLE and S_WRITE. Reset goes to S_IDLE.
- Command bytes are decoded in any state. Any command received in S_WRITE first exits to S_IDLE, then executes.
  - 0x01 WRITE: enter S_WRITE, clear burst counter; ack 0x01.
  - 0x02 PUSH_INDEX: pulse o_push_write_index; ack 0x02.
  - 0x03 POP_INDEX: pulse o_pop_write_index; ack 0x03.
  - 0x04 PUSH_FRAME: pulse o_push_frame; ack 0x04.
  - 0x10 / 0x11: ack = captured size[7:0] / size[15:8].
  - 0x12: ack = captured frames count.
  - 0x13: ack = captured status.
  - Any other opcode: no strobe, ack 0xEE.
- Data byte in S_WRITE with burst counter < WRITE_MAX:
  - o_tx_data = byte, pulse o_tx_data_we.
  - Counter increments (16-bit).
  - Ack echoes the byte.
- Data byte in S_WRITE with counter == WRITE_MAX: dropped, ack 0xEE, state unchanged.
- Data byte in S_IDLE: dropped, ack 0xEE.
- Exactly one ack per detected transfer, including rejected ones.

## Timing
- Host toggle to E: SYNC_STAGES to SYNC_STAGES+1 cycles.
- Strobes (o_tx_data_we, o_push_*, o_pop_*) are high for exactly cycle E+1. o_tx_data is valid at E+1 and holds until the next write.
- o_data is updated and o_sync toggles in the same cycle, E+2. o_data holds until the next ack.
- Transfer spacing: the host must not toggle i_sync again before it sees o_sync flip. A toggle arriving earlier is still detected, because edge detection is one transfer per cycle and capture happens at its own E.
- Reset values: o_data = 0x00, o_sync = 0, o_tx_data = 0x00, all strobes 0, FSM S_IDLE, burst counter 0, synchronizer and previous-value flops 0.
- After reset release, edge detection is masked for SYNC_STAGES+1 cycles while the previous-value flop tracks the synchronizer. A host i_sync held at 1 across reset therefore produces no transfer.
- Reset asserted mid-transfer aborts immediately: no strobe and no ack for the pending byte.

## Configuration
- HOST_ERRCNT_EN defined:
  - Adds an 8-bit saturating counter of rejected transfers (every 0xEE ack). Reset value 0.
  - Opcode 0x14 returns the counter, then clears it in the same cycle as the ack. An error counted in that same cycle yields a post-clear value of 1.
- HOST_ERRCNT_EN undefined: no counter; 0x14 is an unknown opcode (ack 0xEE).

## Test plan
- Reset with i_sync=1, release, wait 10 cycles -> o_sync stays 0, no strobes.
- Cmd 0x01, then data 0xA5, 0x3C -> o_tx_data_we pulses twice with 0xA5, 0x3C at E+1; acks 0x01, 0xA5, 0x3C; o_sync toggles 3 times.
- WRITE_MAX=2: 0x01 then three data bytes -> two we pulses; third ack 0xEE; then cmd 0x04 -> o_push_frame one-cycle pulse, ack 0x04.
- i_tx_data_size=0x1234, i_tx_status=0x81, cmds 0x10, 0x11, 0x13 -> acks 0x34, 0x12, 0x81.
- Data byte in S_IDLE, then opcode 0x7F -> acks 0xEE, 0xEE, no strobes. With HOST_ERRCNT_EN, a following 0x14 -> ack 0x02, and a repeat 0x14 -> ack 0x00.
- Assert i_rst_n low between E and E+2 of a data byte -> no we pulse, o_sync=0, FSM S_IDLE.
